// File: rtl/quad_pkg.sv
// Shared types and phase tables for the quadrature signal generator.
package quad_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Indexed by phase: element 0 is the rest level 11, elements 1..3 the in-detent steps.
  localparam logic [3:0][1:0] CW_SEQ  = {2'b10, 2'b00, 2'b01, 2'b11};
  localparam logic [3:0][1:0] CCW_SEQ = {2'b01, 2'b00, 2'b10, 2'b11};

  localparam logic [1:0] IDLE_LEVEL = 2'b11;

  function automatic logic [1:0] phase_level(input logic dir, input logic [1:0] ph);
    return (dir == DIR_CCW) ? CCW_SEQ[ph] : CW_SEQ[ph];
  endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Phase hold timer: counts QUARTER_CYCLES clocks per phase and flags the last one.
module quad_phase_timer #(
  parameter int QUARTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int TW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(QUARTER_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_signal_gen.sv
// Rotary-encoder quadrature transmitter: turns detent-step commands into CLK/DT
// Gray sequences, each phase held QUARTER_CYCLES clocks, and tracks emitted position.
module quad_signal_gen
  import quad_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int CNT_W          = 8,
  parameter int QUARTER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             CLK,
  output logic             DT,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pos
);

  if (QUARTER_CYCLES < 1) begin : g_bad_quarter
    $error("quad_signal_gen: QUARTER_CYCLES must be >= 1");
  end

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       lvl_q, lvl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             tmr_en, tmr_restart, tick;
  logic [1:0]       next_phase;

  quad_phase_timer #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .en_i      (tmr_en),
    .restart_i (tmr_restart),
    .tick_o    (tick)
  );

  assign next_phase = phase_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    lvl_d       = lvl_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    pos_d       = pos_q;
    tmr_en      = (state_q == RUN);
    tmr_restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          // A zero-detent command completes immediately without leaving IDLE.
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = RUN;
            phase_d     = 2'd1;
            rem_d       = cmd_count;
            dir_d       = cmd_dir;
            lvl_d       = phase_level(cmd_dir, 2'd1);
            busy_d      = 1'b1;
            ready_d     = 1'b0;
            tmr_restart = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick) begin
          if (phase_q == 2'd0) begin
            if (rem_q > CNT_W'(1)) begin
              rem_d   = rem_q - CNT_W'(1);
              phase_d = 2'd1;
              lvl_d   = phase_level(dir_q, 2'd1);
            end else begin
              state_d = IDLE;
              lvl_d   = IDLE_LEVEL;
              busy_d  = 1'b0;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = next_phase;
            lvl_d   = phase_level(dir_q, next_phase);
            // The detent counts once the rest level is driven again.
            if (next_phase == 2'd0) begin
              pos_d = (dir_q == DIR_CW) ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      rem_q   <= '0;
      dir_q   <= DIR_CW;
      lvl_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      pos_q   <= pos_d;
    end
  end

  assign CLK       = lvl_q[1];
  assign DT        = lvl_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_quad_signal_gen.sv
// Bench for quad_signal_gen: table-driven and random commands against a timing model.
module tb_quad_signal_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, cmd_valid, cmd_dir;
  logic [7:0] cmd_count;
  logic       cmd_ready, CLK, DT, busy, done;
  logic [7:0] pos;

  logic       q1_valid, q1_dir;
  logic [7:0] q1_count;
  logic       q1_ready, q1_clk, q1_dt, q1_busy, q1_done;
  logic [7:0] q1_pos;

  quad_signal_gen #(.WIDTH(8), .CNT_W(8), .QUARTER_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .CLK(CLK), .DT(DT),
    .busy(busy), .done(done), .pos(pos)
  );

  quad_signal_gen #(.WIDTH(8), .CNT_W(8), .QUARTER_CYCLES(1)) dut_q1 (
    .clock(clock), .reset(reset), .cmd_valid(q1_valid), .cmd_ready(q1_ready),
    .cmd_dir(q1_dir), .cmd_count(q1_count), .CLK(q1_clk), .DT(q1_dt),
    .busy(q1_busy), .done(q1_done), .pos(q1_pos)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_pos = 0;

  typedef struct {
    bit dir;
    int cnt;
    int exp_pos;
    int exp_busy;
  } vec_t;
  vec_t vecs[6];

  localparam logic [12:0] IDLE_ZERO = {2'b11, 1'b0, 1'b0, 1'b1, 8'd0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic int wrap8(input int x);
    return ((x % 256) + 256) % 256;
  endfunction

  // Expected {CLK,DT,busy,done,cmd_ready,pos} in cycle k after acceptance.
  function automatic logic [12:0] model(input bit dir, input int n, input int start,
                                        input int q, input int k);
    logic [1:0] ord [4];
    logic [1:0] lvl;
    logic       b, d, r;
    int         det, s, p;
    if (dir) ord = '{2'b01, 2'b00, 2'b10, 2'b11};
    else     ord = '{2'b10, 2'b00, 2'b01, 2'b11};
    if (k <= 4 * q * n) begin
      s   = ((k - 1) / q) % 4;
      lvl = ord[s];
      det = (k - 1) / (4 * q) + ((s == 3) ? 1 : 0);
      b = 1'b1; d = 1'b0; r = 1'b0;
    end else begin
      lvl = 2'b11;
      det = n;
      b = 1'b0; d = (k == 4 * q * n + 1); r = 1'b1;
    end
    p = wrap8(start + (dir ? det : -det));
    return {lvl, b, d, r, p[7:0]};
  endfunction

  function automatic logic [12:0] obs();
    return {CLK, DT, busy, done, cmd_ready, pos};
  endfunction

  function automatic logic [12:0] obs1();
    return {q1_clk, q1_dt, q1_busy, q1_done, q1_ready, q1_pos};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called in cycle k=1 after acceptance; returns in the done cycle.
  task automatic follow(input bit dir, input int n, input string tag, output int busy_cycles);
    int start, last;
    start = model_pos;
    last  = 4 * 4 * n + 1;
    busy_cycles = 0;
    for (int k = 1; k <= last; k++) begin
      if (busy) busy_cycles++;
      chk($sformatf("%s k=%0d", tag, k), obs(), model(dir, n, start, 4, k));
      if (k < last) step();
    end
    model_pos = wrap8(start + (dir ? n : -n));
  endtask

  task automatic run_cmd(input bit dir, input int n, input string tag, output int busy_cycles);
    int w;
    w = 0;
    busy_cycles = 0;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_count = 8'(n);
    while (!cmd_ready && w < 500) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      chk({tag, " ready_wait"}, cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    follow(dir, n, tag, busy_cycles);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc, start, gap, n;
    bit dir;
    logic [1:0] prev, cur;

    vecs[0] = '{1'b1, 1, 1,   16};
    vecs[1] = '{1'b0, 3, 254, 48};
    vecs[2] = '{1'b1, 0, 254, 0};
    vecs[3] = '{1'b1, 2, 0,   32};
    vecs[4] = '{1'b0, 1, 255, 16};
    vecs[5] = '{1'b1, 2, 1,   32};

    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = 8'd0;
    q1_valid = 1'b0; q1_dir = 1'b0; q1_count = 8'd0;
    @(negedge clock);
    repeat (3) step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("reset_idle c=%0d", i), obs(), IDLE_ZERO);
      step();
    end
    chk("q1_reset_idle", obs1(), IDLE_ZERO);

    model_pos = 0;
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].dir, vecs[i].cnt, $sformatf("vec%0d", i), bc);
      chk($sformatf("vec%0d busy_cycles", i), bc, vecs[i].exp_busy);
      chk($sformatf("vec%0d end_pos", i), pos, vecs[i].exp_pos);
    end

    // Zero count: done is a single pulse with no level change.
    run_cmd(1'b0, 0, "zero", bc);
    step();
    chk("zero done_clears", obs(), {2'b11, 1'b0, 1'b0, 1'b1, 8'(model_pos)});

    // Back-to-back: second command held valid during the first run.
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = 8'd1;
    step();
    cmd_count = 8'd2;
    follow(1'b1, 1, "b2b_first", bc);
    step();
    cmd_valid = 1'b0;
    follow(1'b1, 2, "b2b_second", bc);
    chk("b2b end_pos", pos, 8'd4);

    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      dir = 1'($urandom_range(0, 1));
      n   = $urandom_range(0, 3);
      run_cmd(dir, n, $sformatf("rnd%0d", i), bc);
      chk($sformatf("rnd%0d busy_cycles", i), bc, 16 * n);
    end

    // Reset in the middle of a CW count=5 run.
    step();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = 8'd5;
    step();
    cmd_valid = 1'b0;
    start = model_pos;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("mid_rst k=%0d", k), obs(), model(1'b1, 5, start, 4, k));
      if (k < 6) step();
    end
    reset = 1'b1;
    step();
    chk("mid_rst after", obs(), IDLE_ZERO);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("mid_rst quiet c=%0d", i), obs(), IDLE_ZERO);
    end
    model_pos = 0;

    // QUARTER_CYCLES=1 instance: a Gray step on every cycle.
    q1_valid = 1'b1; q1_dir = 1'b1; q1_count = 8'd2;
    step();
    q1_valid = 1'b0;
    prev = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("q1 k=%0d", k), obs1(), model(1'b1, 2, 0, 1, k));
      cur = {q1_clk, q1_dt};
      if (k <= 8) chk($sformatf("q1 gray k=%0d", k), $countones(cur ^ prev), 1);
      prev = cur;
      if (k < 9) step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/quad_signal_gen.md
Name: quad_signal_gen

Overview:
- Generates rotary-encoder quadrature waveforms on CLK/DT from detent-step commands. It is the transmitter counterpart of the `encoder` quadrature decoder.
- Used to drive the decoder on-board from an internal pattern source, and as a synthesizable stimulus source for closed-loop benches.
- Keeps its own position count so a loopback check can compare it with the decoder's `pos`.

Parameters:
- WIDTH, 8, width of the position counter `pos`.
- CNT_W, 8, width of the detent count in a command.
- QUARTER_CYCLES, 4, clock cycles each quadrature phase is held. Legal range is >= 1; elaboration fails otherwise.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  generator can accept a command.
- cmd_dir  input  1  1 = clockwise (CW), 0 = counter-clockwise (CCW).
- cmd_count  input  CNT_W  number of detents to emit.
- CLK  output  1  quadrature channel A (idle high).
- DT  output  1  quadrature channel B (idle high).
- busy  output  1  a detent sequence is in progress.
- done  output  1  one-cycle pulse when a command completes.
- pos  output  WIDTH  signed-modulo count of emitted detents.

Behaviour:
- All outputs are registered. Reset state: CLK=1, DT=1, cmd_ready=1, busy=0, done=0, pos=0, state IDLE.
- Reset asserted mid-sequence: on the next edge, outputs return to the reset values; the remaining command is discarded; pos returns to 0.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE. cmd_dir and cmd_count are captured at acceptance. Inputs are ignored while cmd_ready=0.
- Zero count: cmd_count=0 is accepted. State stays IDLE, CLK/DT/pos are unchanged, and done pulses on the following cycle.
- Phase patterns {CLK,DT}, one detent = 4 phases:
  - CW: 01 -> 00 -> 10 -> 11 (CLK leads DT).
  - CCW: 10 -> 00 -> 01 -> 11.
- States: IDLE, RUN (phase index 1..3 then 0, timer, remaining count).
- Timing for a command with count N accepted at edge t0 (Q = QUARTER_CYCLES):
  - Phase 1 is driven for cycles t0+1 .. t0+Q.
  - Phases 2, 3 and 0 (11) follow, each for exactly Q cycles.
  - pos is updated on the edge that drives phase 0, so it is visible from t0+3Q+1. CW adds +1, CCW adds -1, both modulo 2^WIDTH (255 + 1 -> 0, 0 - 1 -> 255).
  - At the end of a phase-0 hold: if remaining > 1, decrement remaining and enter phase 1 of the next detent; else go to IDLE.
  - In IDLE: cmd_ready=1 and done=1 for exactly one cycle, first at t0+4QN+1.
  - busy=1 exactly for cycles t0+1 .. t0+4QN.
- A new command may be accepted in the same cycle done is high; its phase 1 begins on the next cycle.
- CLK and DT never change in the same cycle (Gray sequence). Every transition lasts exactly Q cycles.
- cmd_count = 2^CNT_W-1 must complete without counter overflow.

Decomposition:
- Package quad_pkg holds:
  - state enum {IDLE, RUN};
  - direction constants DIR_CW=1'b1, DIR_CCW=1'b0;
  - phase lookup constants CW_SEQ and CCW_SEQ (4 x 2-bit, indexed by phase);
  - constant IDLE_LEVEL=2'b11.
- One sub-module, quad_phase_timer: a down-counter reloaded to QUARTER_CYCLES-1 that emits a one-cycle `tick` at the end of each phase. It takes clock, reset, an enable and a restart input.

Test Plan (WIDTH=8, CNT_W=8, QUARTER_CYCLES=4 unless stated):
- Reset then idle: {CLK,DT}=11, cmd_ready=1, pos=0, busy=0 held for 20 cycles.
- CW, count=1, accepted at t0: {CLK,DT} sequence is 01@t0+1..4, 00@t0+5..8, 10@t0+9..12, 11@t0+13..16. pos=1 from t0+13. done=1 and cmd_ready=1 at t0+17 only.
- CCW, count=3 from pos=1: sequence 10,00,01,11 three times, 48 busy cycles, pos ends at 254. Feeding CLK/DT into the decoder `encoder` gives a decoder pos that moves by 3 detents in the same direction.
- Back-to-back: second command CW count=2 held valid during the first command's run. It is accepted exactly in the done cycle, with no idle gap, and phase 1 appears on the next cycle.
- Boundaries:
  - count=0 gives a done pulse one cycle after acceptance with no CLK/DT toggle.
  - CW count=2 from pos=255 wraps to 0 then 1.
  - QUARTER_CYCLES=1 gives phase changes every cycle.
- Reset asserted at t0+6 of a CW count=5 command: at t0+7, {CLK,DT}=11, pos=0, cmd_ready=1, busy=0, and there is no done pulse.
